// File: rtl/pipelined_multiplier_pkg.sv
// pipelined_multiplier_pkg: default sizes and width helpers shared by the multiplier slice.
package pipelined_multiplier_pkg;
  localparam int DEF_MULT_WORD_SIZE = 18;
  localparam int DEF_PIPE_STAGES = 3;
  localparam int DEF_TAG_WIDTH = 8;
  function automatic int prod_width(int msw);
    return 2 * msw + 2;
  endfunction
endpackage

// File: rtl/pipelined_multiplier_if.sv
// pipelined_multiplier_if: valid/ready operand and result channels of the multiplier.
interface pipelined_multiplier_if
  import pipelined_multiplier_pkg::*;
#(
  parameter int MULT_WORD_SIZE = DEF_MULT_WORD_SIZE,
  parameter int OUTPUT_WIDTH = 2 * MULT_WORD_SIZE,
  parameter int TAG_WIDTH = DEF_TAG_WIDTH
);
  logic in_valid;
  logic in_ready;
  logic signed [MULT_WORD_SIZE:0] in_a;
  logic signed [MULT_WORD_SIZE:0] in_b;
  logic [TAG_WIDTH-1:0] in_tag;
  logic out_valid;
  logic out_ready;
  logic signed [OUTPUT_WIDTH:0] out;
  logic [TAG_WIDTH-1:0] out_tag;
  logic out_ovf;
  modport master (
    output in_valid, in_a, in_b, in_tag, out_ready,
    input in_ready, out_valid, out, out_tag, out_ovf
  );
  modport slave (
    input in_valid, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out, out_tag, out_ovf
  );
endinterface

// File: rtl/pipelined_multiplier_post_scale.sv
// pipelined_multiplier_post_scale: arithmetic shift and saturation of the full product.
// MULT_ROUND_EN adds round-half-up before the shift.
module pipelined_multiplier_post_scale
  import pipelined_multiplier_pkg::*;
#(
  parameter int MULT_WORD_SIZE = DEF_MULT_WORD_SIZE,
  parameter int OUTPUT_WIDTH = 2 * MULT_WORD_SIZE,
  parameter int PROD_SHIFT = 0,
  localparam int PW = prod_width(MULT_WORD_SIZE)
) (
  input  logic signed [PW-1:0] p,
  output logic signed [OUTPUT_WIDTH:0] res,
  output logic ovf
);
  localparam logic signed [PW:0] ONE = (PW + 1)'(1);
  localparam logic signed [PW:0] OMAX = (ONE <<< OUTPUT_WIDTH) - ONE;
  localparam logic signed [PW:0] OMIN = -(ONE <<< OUTPUT_WIDTH);
  logic signed [PW:0] s;
  function automatic logic [OUTPUT_WIDTH+1:0] sat_to_out(logic signed [PW:0] v);
    return v > OMAX ? {1'b1, OMAX[OUTPUT_WIDTH:0]} :
           v < OMIN ? {1'b1, OMIN[OUTPUT_WIDTH:0]} : {1'b0, v[OUTPUT_WIDTH:0]};
  endfunction
`ifdef MULT_ROUND_EN
  // one extra bit keeps the rounding addend from wrapping before saturation
  localparam logic signed [PW:0] RND = (PROD_SHIFT > 0) ? (ONE <<< (PROD_SHIFT > 0 ? PROD_SHIFT - 1 : 0)) : '0;
  assign s = ($signed({p[PW-1], p}) + RND) >>> PROD_SHIFT;
`else
  assign s = $signed({p[PW-1], p}) >>> PROD_SHIFT;
`endif
  assign {ovf, res} = sat_to_out(s);
endmodule

// File: rtl/pipelined_multiplier.sv
// pipelined_multiplier: valid/ready pipelined signed multiplier with tag passthrough.
// Rounding before the shift is enabled by defining MULT_ROUND_EN.
module pipelined_multiplier
  import pipelined_multiplier_pkg::*;
#(
  parameter int MULT_WORD_SIZE = DEF_MULT_WORD_SIZE,
  parameter int OUTPUT_WIDTH = 2 * MULT_WORD_SIZE,
  parameter int PROD_SHIFT = 0,
  parameter int PIPE_STAGES = DEF_PIPE_STAGES,
  parameter int TAG_WIDTH = DEF_TAG_WIDTH,
  localparam int PW = prod_width(MULT_WORD_SIZE)
) (
  input logic clk_lookup,
  input logic clk_lookup_rst_high,
  pipelined_multiplier_if.slave bus
);
  logic stall;
  logic v [1:PIPE_STAGES];
  logic [TAG_WIDTH-1:0] t [1:PIPE_STAGES];
  logic [PW-1:0] d [1:PIPE_STAGES-1];
  logic signed [PW-1:0] ea, eb, prod, pre;
  logic signed [OUTPUT_WIDTH:0] res, out_q;
  logic ovf, ovf_q;
  assign stall = v[PIPE_STAGES] && !bus.out_ready;
  assign bus.in_ready = !stall;
  assign bus.out_valid = v[PIPE_STAGES];
  assign bus.out_tag = t[PIPE_STAGES];
  assign bus.out = out_q;
  assign bus.out_ovf = ovf_q;
  // stage 1 packs {a, b}, which is exactly PW bits wide
  assign ea = PW'($signed(d[1][PW-1:MULT_WORD_SIZE+1]));
  assign eb = PW'($signed(d[1][MULT_WORD_SIZE:0]));
  assign prod = ea * eb;
  assign pre = PIPE_STAGES == 2 ? prod : d[PIPE_STAGES-1];
  pipelined_multiplier_post_scale #(
    .MULT_WORD_SIZE(MULT_WORD_SIZE),
    .OUTPUT_WIDTH(OUTPUT_WIDTH),
    .PROD_SHIFT(PROD_SHIFT)
  ) u_post_scale (
    .p(pre),
    .res(res),
    .ovf(ovf)
  );
  for (genvar i = 1; i <= PIPE_STAGES; i++) begin : g_stage
    if (i == 1) begin : g_in
      always_ff @(posedge clk_lookup or posedge clk_lookup_rst_high)
        if (clk_lookup_rst_high) begin
          v[1] <= 1'b0;
          t[1] <= '0;
          d[1] <= '0;
        end else if (!stall) begin
          v[1] <= bus.in_valid;
          if (bus.in_valid) begin
            t[1] <= bus.in_tag;
            d[1] <= {bus.in_a, bus.in_b};
          end
        end
    end else if (i == PIPE_STAGES) begin : g_out
      always_ff @(posedge clk_lookup or posedge clk_lookup_rst_high)
        if (clk_lookup_rst_high) begin
          v[i] <= 1'b0;
          t[i] <= '0;
          out_q <= '0;
          ovf_q <= 1'b0;
        end else if (!stall) begin
          v[i] <= v[i-1];
          if (v[i-1]) begin
            t[i] <= t[i-1];
            out_q <= res;
            ovf_q <= ovf;
          end
        end
    end else begin : g_mid
      always_ff @(posedge clk_lookup or posedge clk_lookup_rst_high)
        if (clk_lookup_rst_high) begin
          v[i] <= 1'b0;
          t[i] <= '0;
          d[i] <= '0;
        end else if (!stall) begin
          v[i] <= v[i-1];
          if (v[i-1]) begin
            t[i] <= t[i-1];
            d[i] <= i == 2 ? prod : d[i-1];
          end
        end
    end
  end
endmodule

// File: tb/tb_pipelined_multiplier.sv
// tb_pipelined_multiplier: directed checks of the default, shifted/2-stage and 8-stage multipliers.
module tb_pipelined_multiplier;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  localparam longint OMAX = 64'sh0000_000F_FFFF_FFFF;
  localparam longint OMIN = -OMAX - 1;
`ifdef MULT_ROUND_EN
  localparam int R0 = 3;
`else
  localparam int R0 = 2;
`endif
  always #5 clk = ~clk;

  pipelined_multiplier_if m0 ();
  pipelined_multiplier_if m1 ();
  pipelined_multiplier_if m2 ();

  pipelined_multiplier u0 (.clk_lookup(clk), .clk_lookup_rst_high(rst), .bus(m0.slave));
  pipelined_multiplier #(.PROD_SHIFT(4), .PIPE_STAGES(2)) u1 (.clk_lookup(clk), .clk_lookup_rst_high(rst), .bus(m1.slave));
  pipelined_multiplier #(.PIPE_STAGES(8)) u2 (.clk_lookup(clk), .clk_lookup_rst_high(rst), .bus(m2.slave));

  function automatic logic [37:0] model(longint a, longint b, int sh);
    longint s = a * b;
`ifdef MULT_ROUND_EN
    if (sh > 0) s += longint'(1) <<< (sh - 1);
`endif
    s = s >>> sh;
    if (s > OMAX) return {1'b1, OMAX[36:0]};
    if (s < OMIN) return {1'b1, OMIN[36:0]};
    return {1'b0, s[36:0]};
  endfunction

  task automatic send0(input logic signed [18:0] a, input logic signed [18:0] b, input logic [7:0] tag, output int lat);
    @(posedge clk); #1;
    m0.in_valid = 1'b1; m0.in_a = a; m0.in_b = b; m0.in_tag = tag;
    @(posedge clk); #1;
    m0.in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!m0.out_valid && lat < 20);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (m0.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", m0.out_valid); end
    n_checks++; if (m0.out !== '0) begin n_fail++; $display("FAIL reset_out: got %0d expected 0", m0.out); end
    n_checks++; if ({m0.out_tag, m0.out_ovf} !== 9'd0) begin n_fail++; $display("FAIL reset_tag_ovf: got %h/%b expected 0/0", m0.out_tag, m0.out_ovf); end
    n_checks++; if (m2.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid_p8: got %b expected 0", m2.out_valid); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (m0.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", m0.in_ready); end
  endtask

  task automatic test_basic();
    int lat;
    send0(19'sd3, -19'sd5, 8'h11, lat);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL basic_latency: got %0d expected 3", lat); end
    n_checks++; if (m0.out !== -37'sd15) begin n_fail++; $display("FAIL basic_out: got %0d expected -15", m0.out); end
    n_checks++; if (m0.out_ovf !== 1'b0) begin n_fail++; $display("FAIL basic_ovf: got %b expected 0", m0.out_ovf); end
    n_checks++; if (m0.out_tag !== 8'h11) begin n_fail++; $display("FAIL basic_tag: got %h expected 11", m0.out_tag); end
    @(negedge clk);
    n_checks++; if ({m0.out_valid, m0.out} !== {1'b0, -37'sd15}) begin n_fail++; $display("FAIL basic_hold: got v=%b out=%0d expected v=0 out=-15", m0.out_valid, m0.out); end
  endtask

  task automatic test_corner();
    int lat;
    send0(-19'sd262144, -19'sd262144, 8'h01, lat);
    n_checks++; if (m0.out !== 37'sh0F_FFFF_FFFF) begin n_fail++; $display("FAIL corner_sat_out: got %0d expected 68719476735", m0.out); end
    n_checks++; if (m0.out_ovf !== 1'b1) begin n_fail++; $display("FAIL corner_sat_ovf: got %b expected 1", m0.out_ovf); end
    send0(-19'sd262144, 19'sd262143, 8'h02, lat);
    n_checks++; if (m0.out !== -37'sd68719214592) begin n_fail++; $display("FAIL corner_min_out: got %0d expected -68719214592", m0.out); end
    n_checks++; if (m0.out_ovf !== 1'b0) begin n_fail++; $display("FAIL corner_min_ovf: got %b expected 0", m0.out_ovf); end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          logic ok;
          m0.in_valid = 1'b1; m0.in_a = 19'(i); m0.in_b = 19'(i + 1); m0.in_tag = 8'(i);
          do begin
            @(negedge clk);
            ok = m0.in_ready;
            @(posedge clk); #1;
          end while (!ok);
        end
        m0.in_valid = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        #1 m0.out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          n_checks++; if (m0.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b expected 0", m0.in_ready); end
        end
        @(posedge clk); #1 m0.out_ready = 1'b1;
      end
      begin
        int cyc = 0;
        while (n < 16 && cyc < 100) begin
          @(negedge clk);
          cyc++;
          if (m0.out_valid && m0.out_ready) begin
            n_checks++; if (m0.out_tag !== 8'(n)) begin n_fail++; $display("FAIL stream_tag: got %0d expected %0d", m0.out_tag, n); end
            n_checks++; if (m0.out !== 37'(n * (n + 1))) begin n_fail++; $display("FAIL stream_out: got %0d expected %0d", m0.out, n * (n + 1)); end
            n++;
          end
        end
      end
    join
    n_checks++; if (n !== 16) begin n_fail++; $display("FAIL stream_count: got %0d expected 16", n); end
    @(negedge clk);
    n_checks++; if (m0.out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_extra: got %b expected 0", m0.out_valid); end
  endtask

  task automatic test_reset_midflight();
    int lat;
    logic seen = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      m0.in_valid = 1'b1; m0.in_a = 19'(i + 1); m0.in_b = 19'sd2; m0.in_tag = 8'(8'h21 + i);
      @(posedge clk); #1;
    end
    m0.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++; if (m0.out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b expected 0", m0.out_valid); end
    n_checks++; if (m0.out !== '0) begin n_fail++; $display("FAIL midreset_out: got %0d expected 0", m0.out); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= m0.out_valid;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midreset_ghost: got %b expected 0", seen); end
    send0(19'sd7, 19'sd6, 8'h30, lat);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL midreset_latency: got %0d expected 3", lat); end
    n_checks++; if ({m0.out_tag, m0.out} !== {8'h30, 37'sd42}) begin n_fail++; $display("FAIL midreset_beat: got %h/%0d expected 30/42", m0.out_tag, m0.out); end
  endtask

  task automatic test_depths();
    logic signed [18:0] ta [24];
    logic signed [18:0] tb [24];
    int n1 = 0, n2 = 0;
    ta[0] = 19'sd42; tb[0] = 19'sd1;
    ta[1] = -19'sd42; tb[1] = 19'sd1;
    ta[2] = -19'sd262144; tb[2] = -19'sd262144;
    ta[3] = -19'sd262144; tb[3] = 19'sd262143;
    for (int i = 4; i < 24; i++) begin
      ta[i] = 19'($urandom);
      tb[i] = 19'($urandom);
    end
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          m1.in_valid = 1'b1; m1.in_a = ta[i]; m1.in_b = tb[i]; m1.in_tag = 8'(i);
          m2.in_valid = 1'b1; m2.in_a = ta[i]; m2.in_b = tb[i]; m2.in_tag = 8'(i);
          @(posedge clk); #1;
        end
        m1.in_valid = 1'b0;
        m2.in_valid = 1'b0;
      end
      begin
        int cnt = -1;
        while (n1 < 24 && cnt < 80) begin
          @(negedge clk);
          cnt++;
          if (m1.out_valid) begin
            if (n1 == 0) begin
              n_checks++; if (cnt !== 2) begin n_fail++; $display("FAIL p2_latency: got %0d expected 2", cnt); end
              n_checks++; if (m1.out !== 37'(R0)) begin n_fail++; $display("FAIL shift_pos: got %0d expected %0d", m1.out, R0); end
            end
            if (n1 == 1) begin
              n_checks++; if (m1.out !== -37'sd3) begin n_fail++; $display("FAIL shift_neg: got %0d expected -3", m1.out); end
            end
            n_checks++; if (m1.out_tag !== 8'(n1)) begin n_fail++; $display("FAIL p2_tag: got %0d expected %0d", m1.out_tag, n1); end
            n_checks++; if ({m1.out_ovf, m1.out} !== model(ta[n1], tb[n1], 4)) begin n_fail++; $display("FAIL p2_value: got %b/%0d expected %h", m1.out_ovf, m1.out, model(ta[n1], tb[n1], 4)); end
            n1++;
          end
        end
      end
      begin
        int cnt = -1;
        while (n2 < 24 && cnt < 80) begin
          @(negedge clk);
          cnt++;
          if (m2.out_valid) begin
            if (n2 == 0) begin
              n_checks++; if (cnt !== 8) begin n_fail++; $display("FAIL p8_latency: got %0d expected 8", cnt); end
            end
            n_checks++; if (m2.out_tag !== 8'(n2)) begin n_fail++; $display("FAIL p8_tag: got %0d expected %0d", m2.out_tag, n2); end
            n_checks++; if ({m2.out_ovf, m2.out} !== model(ta[n2], tb[n2], 0)) begin n_fail++; $display("FAIL p8_value: got %b/%0d expected %h", m2.out_ovf, m2.out, model(ta[n2], tb[n2], 0)); end
            n2++;
          end
        end
      end
    join
    n_checks++; if (n1 !== 24 || n2 !== 24) begin n_fail++; $display("FAIL depth_count: got %0d/%0d expected 24/24", n1, n2); end
  endtask

  initial begin
    m0.in_valid = 1'b0; m0.in_a = '0; m0.in_b = '0; m0.in_tag = '0; m0.out_ready = 1'b1;
    m1.in_valid = 1'b0; m1.in_a = '0; m1.in_b = '0; m1.in_tag = '0; m1.out_ready = 1'b1;
    m2.in_valid = 1'b0; m2.in_a = '0; m2.in_b = '0; m2.in_tag = '0; m2.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_corner();
    test_back_to_back();
    test_reset_midflight();
    test_depths();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
